tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Shares one free-running prescaler counter among NCH consumers.
- Each channel has a programmable power-of-two period and emits single-cycle clock-enable strobes (`tick`).
- This replaces ad-hoc divided clocks in game logic, display refresh and input debounce with enables in the main `clk` domain.
- A valid/ready config port retimes channel changes so that no strobe is ever runt or doubled.

Parameters:
- CNT_W, 27, prescaler counter width.
- NCH, 4, number of tick channels.
- SEL_W, 5, width of the per-channel period selector.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  reset; synchronous, active-high.
- sync  in  1  one-cycle pulse; clears the prescaler to restart all phases.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  block can accept a config request.
- cfg_ch  in  $clog2(NCH)  target channel.
- cfg_sel  in  SEL_W  period exponent; period = 2^(cfg_sel+1) cycles.
- cfg_en  in  1  channel enable.
- tick  out  NCH  per-channel one-cycle enable strobes.
- ch_en  out  NCH  current enable state of each channel.

Behaviour:
- Reset (rst=1 at a clk edge):
  - prescaler cleared to 0; all channel sel cleared to 0; ch_en=0; tick=0.
  - FSM returns to IDLE and any pending config is discarded.
  - cfg_ready=0 while rst is high; cfg_ready=1 from the first cycle after rst deasserts.
- Prescaler:
  - cnt increments by 1 every cycle and wraps from 2^CNT_W-1 to 0.
  - sync=1 forces cnt to 0 on the next edge; rst has priority over sync.
- Boundary condition: boundary(i) = (ch_en[i] && cnt[sel_i:0] all ones).
- Tick timing:
  - tick is registered: tick[i] is high in cycle t+1 iff boundary(i) held in cycle t.
  - Strobes are exactly one cycle wide, with period 2^(sel_i+1).
- Selector clamping: a cfg_sel value above CNT_W-1 is clamped to CNT_W-1 when it is stored.
- FSM states: IDLE, WAIT.
  - IDLE: cfg_ready=1. On cfg_valid && cfg_ready, latch ch/sel/en.
    - If the target channel is disabled, apply the config on the next edge and stay in IDLE.
    - Otherwise go to WAIT.
  - WAIT: cfg_ready=0. When boundary(target) holds under the OLD config, that tick is still issued with the old config. The new sel/en are written on the same edge and the FSM returns to IDLE.
  - Result: a disable is preceded by one final full-period tick, and a retune starts a fresh period.
- sync during WAIT: the counter restarts and WAIT continues, evaluated against the new counter values.
- A request to a channel with identical sel/en is still handshaked and follows the normal path.
- Requests to other channels are not accepted during WAIT (single outstanding request).
- cfg_ch >= NCH: the request is accepted and ignored; the FSM stays in IDLE.

Optional Feature:
- Macro: TICK_SCHED_CLKOUT_EN.
- When defined:
  - extra output `clk_div [NCH-1:0]` = cnt[sel_i] when ch_en[i], else 0.
  - This is a 50% duty square wave for legacy consumers.
  - It is combinational from registered state and changes only at clk edges.
- When undefined: the port and logic are absent; tick behaviour is identical in both builds.

Decomposition:
- Package `tick_sched_pkg` holds:
  - the state enum {IDLE, WAIT};
  - constants CNT_W_DEF=27 and SEL_MAX=CNT_W_DEF-1;
  - a `ch_cfg_t` struct {sel, en}.
- One sub-module, `tick_channel`: holds one channel's sel/en registers and its boundary compare and tick register. It is instantiated NCH times.
- The FSM and the prescaler live in the top level.

Test Plan:
- Reset, then cfg ch0 sel=0 en=1 (channel was disabled, so the config applies immediately) -> tick[0] pulses on every 2nd cycle; ch_en=4'b0001.
- ch1 running sel=2 (period 8); request sel=3 mid-period -> cfg_ready low until the old boundary; one last tick at period 8, then ticks every 16 cycles; no two ticks closer than 8 cycles.
- Disable ch0 (sel=1) -> exactly one further tick 4 cycles after the previous tick, then none; cfg_ready returns to 1 the cycle after.
- Pulse sync with ch2 at sel=4 -> the next tick arrives 32 cycles after sync plus the 1-cycle register latency; assert rst mid-WAIT -> FSM in IDLE, all ch_en=0, tick=0 the next cycle.
- cfg_sel=31 -> stored as 26; with the prescaler preloaded near wrap via force, tick arrives at the cnt[26:0]=all-ones boundary.
- TICK_SCHED_CLKOUT_EN build, ch3 sel=1 -> clk_div[3] toggles every 2 cycles (period 4, high 2 cycles, low 2 cycles); tick[3] waveform matches the non-macro build.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared types and constants for tick_scheduler.
//   state_t   - config retiming FSM states (IDLE, WAIT)
//   ch_cfg_t  - one channel's stored configuration {sel, en}
//   clamp_sel - limits a period exponent to the widest prescaler bit
package tick_sched_pkg;

    localparam int unsigned CNT_W_DEF = 27;
    localparam int unsigned SEL_MAX   = CNT_W_DEF - 1;
    localparam int unsigned SEL_W_DEF = 5;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef struct packed {
        logic [SEL_W_DEF-1:0] sel;
        logic                 en;
    } ch_cfg_t;

    function automatic logic [SEL_W_DEF-1:0] clamp_sel(input int unsigned sel,
                                                       input int unsigned max_sel);
        return SEL_W_DEF'((sel > max_sel) ? max_sel : sel);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one tick channel of tick_scheduler.
// Holds the channel's sel/en registers, compares the shared prescaler against
// the channel's period mask and registers the resulting strobe.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   cnt       - shared prescaler value
//   wr        - write wr_cfg into the channel registers on this edge
//   wr_cfg    - new {sel, en} (sel already clamped)
//   boundary  - combinational: channel enabled and cnt[sel:0] all ones
//   tick      - registered one-cycle strobe (boundary delayed one cycle)
//   en        - current enable state
//   clk_div   - only with TICK_SCHED_CLKOUT_EN: cnt[sel] gated by en
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic             wr,
    input  ch_cfg_t          wr_cfg,
    output logic             boundary,
    output logic             tick,
    output logic             en
`ifdef TICK_SCHED_CLKOUT_EN
    ,
    output logic             clk_div
`endif
);

    logic [SEL_W_DEF-1:0] sel;
    logic [CNT_W-1:0]     mask;

    // Low sel+1 bits set: boundary when all those prescaler bits are ones.
    always_comb begin
        mask = '0;
        for (int unsigned b = 0; b < CNT_W; b++) begin
            mask[b] = (b <= 32'(sel));
        end
    end

    assign boundary = en && ((cnt & mask) == mask);

    // The tick register samples boundary under the config held before a
    // write, so the final old-period strobe survives a same-edge update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= '0;
            en   <= 1'b0;
            tick <= 1'b0;
        end else begin
            tick <= boundary;
            if (wr) begin
                sel <= wr_cfg.sel;
                en  <= wr_cfg.en;
            end
        end
    end

`ifdef TICK_SCHED_CLKOUT_EN
    assign clk_div = en && cnt[sel];
`endif

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared free-running prescaler driving NCH clock-enable
// channels with power-of-two periods (period = 2^(sel+1) cycles).
// Config changes go through a valid/ready port; changes to a running channel
// are held until its current period ends so strobes are never runt or doubled.
// Optional build macro: TICK_SCHED_CLKOUT_EN adds clk_div square-wave outputs.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   sync       - one-cycle pulse, restarts the prescaler at 0
//   cfg_valid  - config request valid
//   cfg_ready  - request can be accepted (IDLE and not in reset)
//   cfg_ch     - target channel (>= NCH is accepted and ignored)
//   cfg_sel    - period exponent, clamped to CNT_W-1 when stored
//   cfg_en     - channel enable
//   tick       - per-channel one-cycle strobes
//   ch_en      - per-channel enable state
//   clk_div    - (TICK_SCHED_CLKOUT_EN) 50% duty divided clocks
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SEL_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sync,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [SEL_W-1:0]       cfg_sel,
    input  logic                   cfg_en,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         ch_en
`ifdef TICK_SCHED_CLKOUT_EN
    ,
    output logic [NCH-1:0]         clk_div
`endif
);

    localparam int unsigned CH_W = $clog2(NCH);

    logic [CNT_W-1:0] cnt;
    state_t           state, state_n;
    logic [CH_W-1:0]  pend_ch;
    ch_cfg_t          pend_cfg;
    ch_cfg_t          req_cfg;
    ch_cfg_t          wr_cfg;
    logic [NCH-1:0]   wr;
    logic [NCH-1:0]   boundary;
    logic             req_ok;
    logic             pend_load;

    always_ff @(posedge clk) begin
        if (rst || sync) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign req_cfg = '{sel: clamp_sel(32'(cfg_sel), CNT_W - 1), en: cfg_en};
    assign req_ok  = (32'(cfg_ch) < NCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend_ch  <= '0;
            pend_cfg <= '0;
        end else begin
            state <= state_n;
            if (pend_load) begin
                pend_ch  <= cfg_ch;
                pend_cfg <= req_cfg;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cfg_ready = 1'b0;
        wr        = '0;
        wr_cfg    = req_cfg;
        pend_load = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = !rst;
                if (cfg_valid && !rst && req_ok) begin
                    // A disabled channel has no period in flight to protect.
                    if (!ch_en[cfg_ch]) begin
                        wr[cfg_ch] = 1'b1;
                    end else begin
                        pend_load = 1'b1;
                        state_n   = WAIT;
                    end
                end
            end
            WAIT: begin
                wr_cfg = pend_cfg;
                if (boundary[pend_ch]) begin
                    wr[pend_ch] = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .cnt      (cnt),
            .wr       (wr[i]),
            .wr_cfg   (wr_cfg),
            .boundary (boundary[i]),
            .tick     (tick[i]),
            .en       (ch_en[i])
`ifdef TICK_SCHED_CLKOUT_EN
            ,
            .clk_div  (clk_div[i])
`endif
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: scoreboard bench for tick_scheduler.
// A behavioural model (modular arithmetic on a counter value) pushes the
// expected outputs of every cycle; a negedge monitor pops and compares.
module tb_tick_scheduler;

    localparam int NCH   = 4;
    localparam int CNT_W = 27;
    localparam longint unsigned MOD = 64'd1 << CNT_W;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [4:0] cfg_sel;
    logic       cfg_en;
    logic [3:0] tick;
    logic [3:0] ch_en;
`ifdef TICK_SCHED_CLKOUT_EN
    logic [3:0] clk_div;
`endif

    always #5 clk = ~clk;

    tick_scheduler #(
        .CNT_W(CNT_W),
        .NCH  (NCH),
        .SEL_W(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_en   (cfg_en),
        .tick     (tick),
        .ch_en    (ch_en)
`ifdef TICK_SCHED_CLKOUT_EN
        ,
        .clk_div  (clk_div)
`endif
    );

    typedef struct {
        logic [3:0] tick;
        logic [3:0] en;
        logic       idle;
        logic [3:0] div;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    longint unsigned m_cnt = 0;
    int              m_sel[NCH];
    bit              m_en[NCH];
    bit              m_pend = 0;
    int              p_ch, p_sel;
    bit              p_en;

    function automatic bit at_edge(int ch);
        longint unsigned p;
        p = 64'd1 << (m_sel[ch] + 1);
        return m_en[ch] && ((m_cnt % p) == p - 1);
    endfunction

    function automatic int clampv(int s);
        return (s > CNT_W - 1) ? CNT_W - 1 : s;
    endfunction

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_sel[i] = 0;
            m_en[i]  = 0;
        end
    end

    always @(posedge clk) begin : model
        exp_t     e;
        bit [3:0] b;
        int       ch;
        for (int i = 0; i < NCH; i++) b[i] = at_edge(i);
        if (rst) begin
            m_cnt  = 0;
            m_pend = 0;
            for (int i = 0; i < NCH; i++) begin
                m_sel[i] = 0;
                m_en[i]  = 0;
            end
            e.tick = '0;
        end else begin
            e.tick = b;
            if (m_pend) begin
                if (b[p_ch]) begin
                    m_sel[p_ch] = p_sel;
                    m_en[p_ch]  = p_en;
                    m_pend      = 0;
                end
            end else if (cfg_valid) begin
                ch = int'(cfg_ch);
                if (ch < NCH) begin
                    if (!m_en[ch]) begin
                        m_sel[ch] = clampv(int'(cfg_sel));
                        m_en[ch]  = cfg_en;
                    end else begin
                        m_pend = 1;
                        p_ch   = ch;
                        p_sel  = clampv(int'(cfg_sel));
                        p_en   = cfg_en;
                    end
                end
            end
            m_cnt = sync ? 0 : (m_cnt + 1) % MOD;
        end
        for (int i = 0; i < NCH; i++) begin
            e.en[i]  = m_en[i];
            e.div[i] = m_en[i] && (((m_cnt >> m_sel[i]) & 1) == 1);
        end
        e.idle = !m_pend;
        q.push_back(e);
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("tick", tick, e.tick);
            chk("ch_en", ch_en, e.en);
            chk("cfg_ready", {3'b000, cfg_ready}, {3'b000, e.idle && !rst});
`ifdef TICK_SCHED_CLKOUT_EN
            chk("clk_div", clk_div, e.div);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int ch, input int sel, input bit en);
        int n;
        n         = 0;
        cfg_ch    = 2'(ch);
        cfg_sel   = 5'(sel);
        cfg_en    = en;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 400) begin
            step();
            n++;
        end
        tests++;
        if (!cfg_ready) begin
            fails++;
            $display("FAIL handshake_timeout: cfg_ready got 0 expected 1 within 400 cycles");
        end else begin
            step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_sel   = '0;
        cfg_en    = 1'b0;
        steps(3);
        rst = 1'b0;
        step();

        // Enable a disabled channel: immediate apply
        send(0, 0, 1);
        steps(10);
        // Retune a running channel mid-period
        send(1, 2, 1);
        steps(5);
        send(1, 3, 1);
        steps(40);
        // Slow ch0 down, then disable it
        send(0, 1, 1);
        steps(9);
        send(0, 1, 0);
        steps(10);
        // Sync with ch2 running at period 32
        send(2, 4, 1);
        steps(7);
        pulse_sync();
        steps(40);
        // Reset while a retune is pending
        send(2, 1, 1);
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(3);

        // Randomized traffic, short periods to bound WAIT
        for (int t = 0; t < 80; t++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) < 7));
            steps(int'($urandom_range(0, 20)));
            if ($urandom_range(0, 7) == 0) pulse_sync();
        end

        // Clamp and prescaler wrap
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        force dut.cnt = 27'(MOD - 40);
        m_cnt = MOD - 40;
        #2;
        release dut.cnt;
        step();
        send(3, 31, 1);
        steps(60);

        steps(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
